classifier_arbiter: RTL and testbench

Shares one classifier_Classifier instance among N_CHANNELS frame producers, such as per-microphone FFT pipelines. The block does three things:
- Round-robin arbitrates whole-frame requests, buffers the granted frame, issues it to the classifier, and routes the 1-bit result back to the owning channel.
- Serialises configuration writes (cutoff freq, cutoff mag, sampling freq) onto the classifier's three config ports, but only between frames.
- Sits directly upstream and downstream of the classifier in the audio top level.

---
 rtl/classifier_arbiter_pkg.sv | 8 +
 rtl/classifier_rr_arbiter.sv | 20 ++
 rtl/classifier_arbiter.sv | 121 ++++++++++++
 tb/tb_classifier_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/classifier_arbiter_pkg.sv
// classifier_arbiter_pkg: FSM states and config address codes shared by the classifier arbiter
package classifier_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] CFG_CUTOFF_FREQ   = 2'd0;
  localparam logic [1:0] CFG_CUTOFF_MAG    = 2'd1;
  localparam logic [1:0] CFG_SAMPLING_FREQ = 2'd2;
  localparam logic [1:0] CFG_INVALID       = 2'd3;
endpackage

// File: rtl/classifier_rr_arbiter.sv
// classifier_rr_arbiter: round-robin pick of the first request at or after the pointer
module classifier_rr_arbiter #(
  parameter int N_CHANNELS = 4,
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [CH_W-1:0]       ptr,
  output logic [N_CHANNELS-1:0] gnt,
  output logic [CH_W-1:0]       idx,
  output logic                  any
);
  assign any = |req;
  assign gnt = any ? N_CHANNELS'(1) << idx : '0;
  // scan farthest offset first so the nearest request at or after ptr wins
  always_comb begin
    idx = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--)
      if (req[CH_W'((int'(ptr) + i) % N_CHANNELS)]) idx = CH_W'((int'(ptr) + i) % N_CHANNELS);
  end
endmodule

// File: rtl/classifier_arbiter.sv
// classifier_arbiter: shares one classifier among N_CHANNELS frame producers and
// serialises config writes onto the classifier's config ports between frames
module classifier_arbiter
  import classifier_arbiter_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int N_SAMPLES  = 8,
  parameter int N_CHANNELS = 4,
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] req_val,
  output logic [N_CHANNELS-1:0] req_rdy,
  input  logic [BIT_WIDTH-1:0]  req_msg [N_CHANNELS][N_SAMPLES],
  output logic [N_CHANNELS-1:0] resp_val,
  input  logic [N_CHANNELS-1:0] resp_rdy,
  output logic [N_CHANNELS-1:0] resp_msg,
  input  logic                  cfg_val,
  output logic                  cfg_rdy,
  input  logic [1:0]            cfg_addr,
  input  logic [BIT_WIDTH-1:0]  cfg_data,
  output logic                  cls_recv_val,
  input  logic                  cls_recv_rdy,
  output logic [BIT_WIDTH-1:0]  cls_recv_msg [N_SAMPLES],
  output logic                  cls_cutoff_freq_val,
  input  logic                  cls_cutoff_freq_rdy,
  output logic [BIT_WIDTH-1:0]  cls_cutoff_freq_msg,
  output logic                  cls_cutoff_mag_val,
  input  logic                  cls_cutoff_mag_rdy,
  output logic [BIT_WIDTH-1:0]  cls_cutoff_mag_msg,
  output logic                  cls_sampling_freq_val,
  input  logic                  cls_sampling_freq_rdy,
  output logic [BIT_WIDTH-1:0]  cls_sampling_freq_msg,
  input  logic                  cls_send_val,
  output logic                  cls_send_rdy,
  input  logic                  cls_send_msg,
  output logic [CH_W-1:0]       owner,
  output logic                  busy,
  output logic                  cfg_err
);
  state_t state, state_nx;
  logic [CH_W-1:0] ptr, g_idx;
  logic [N_CHANNELS-1:0] g_onehot;
  logic any_req, cfg_go, req_go, cfg_prio, result, port_rdy;
  logic [1:0] addr_q;
  logic [BIT_WIDTH-1:0] data_q;
  logic [BIT_WIDTH-1:0] frame [N_SAMPLES];

  classifier_rr_arbiter #(.N_CHANNELS(N_CHANNELS)) u_rr (
    .req(req_val),
    .ptr(ptr),
    .gnt(g_onehot),
    .idx(g_idx),
    .any(any_req)
  );

  // handshake rdys are combinational, so they are gated by reset to stay low while it is held
  assign cfg_go  = reset && state == IDLE && cfg_val && (cfg_prio || !any_req);
  assign req_go  = reset && state == IDLE && !cfg_go && any_req;
  assign cfg_rdy = cfg_go;
  assign req_rdy = req_go ? g_onehot : '0;

  assign port_rdy = addr_q == CFG_CUTOFF_FREQ   ? cls_cutoff_freq_rdy :
                    addr_q == CFG_CUTOFF_MAG    ? cls_cutoff_mag_rdy :
                    addr_q == CFG_SAMPLING_FREQ ? cls_sampling_freq_rdy : 1'b1;

  assign cls_cutoff_freq_val   = state == CFG && addr_q == CFG_CUTOFF_FREQ;
  assign cls_cutoff_mag_val    = state == CFG && addr_q == CFG_CUTOFF_MAG;
  assign cls_sampling_freq_val = state == CFG && addr_q == CFG_SAMPLING_FREQ;
  assign cls_cutoff_freq_msg   = data_q;
  assign cls_cutoff_mag_msg    = data_q;
  assign cls_sampling_freq_msg = data_q;
  assign cls_recv_val = state == ISSUE;
  assign cls_recv_msg = frame;
  assign cls_send_rdy = state == WAIT;
  assign resp_val = state == RESP ? N_CHANNELS'(1) << owner : '0;
  assign resp_msg = result ? resp_val : '0;
  assign busy = state != IDLE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cfg_go ? CFG : req_go ? ISSUE : IDLE;
      CFG:     state_nx = port_rdy ? IDLE : CFG;
      ISSUE:   state_nx = cls_recv_rdy ? WAIT : ISSUE;
      WAIT:    state_nx = cls_send_val ? RESP : WAIT;
      RESP:    state_nx = resp_rdy[owner] ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cfg_prio <= 1'b1;
      cfg_err  <= 1'b0;
      result   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int s = 0; s < N_SAMPLES; s++) frame[s] <= '0;
    end else begin
      state <= state_nx;
      if (cfg_go) begin
        addr_q   <= cfg_addr;
        data_q   <= cfg_data;
        cfg_prio <= 1'b0;
        cfg_err  <= cfg_err | (cfg_addr == CFG_INVALID);
      end
      if (req_go) begin
        for (int s = 0; s < N_SAMPLES; s++) frame[s] <= req_msg[g_idx][s];
        owner    <= g_idx;
        cfg_prio <= 1'b1;
      end
      if (state == WAIT && cls_send_val) result <= cls_send_msg;
      if (state == RESP && resp_rdy[owner]) ptr <= owner == CH_W'(N_CHANNELS - 1) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_classifier_arbiter.sv
// tb_classifier_arbiter: table-driven and scoreboard checks of grant order, config serialisation and reset abort
module tb_classifier_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req_val = '0, req_rdy, resp_val, resp_msg;
  logic [3:0] resp_rdy = 4'hF;
  logic [31:0] frames [4][8];
  logic cfg_val = 1'b0, cfg_rdy;
  logic [1:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic cls_recv_val, cls_recv_rdy = 1'b0;
  logic [31:0] cls_recv_msg [8];
  logic freq_val, mag_val, samp_val;
  logic freq_rdy = 1'b1, mag_rdy = 1'b1, samp_rdy = 1'b1;
  logic [31:0] freq_msg, mag_msg, samp_msg;
  logic cls_send_val = 1'b0, cls_send_rdy, cls_send_msg = 1'b0;
  logic [1:0] owner;
  logic busy, cfg_err;
  logic err_exp = 1'b0;
  int checks = 0, errors = 0;

  typedef struct { int ch; bit res; } exp_t;
  exp_t sb [$];
  typedef struct { int ch; bit res; logic [3:0] drop; } fvec_t;
  typedef struct { logic [1:0] a; logic [31:0] d; } cvec_t;

  classifier_arbiter #(.BIT_WIDTH(32), .N_SAMPLES(8), .N_CHANNELS(4)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(frames),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cls_recv_val(cls_recv_val), .cls_recv_rdy(cls_recv_rdy), .cls_recv_msg(cls_recv_msg),
    .cls_cutoff_freq_val(freq_val), .cls_cutoff_freq_rdy(freq_rdy), .cls_cutoff_freq_msg(freq_msg),
    .cls_cutoff_mag_val(mag_val), .cls_cutoff_mag_rdy(mag_rdy), .cls_cutoff_mag_msg(mag_msg),
    .cls_sampling_freq_val(samp_val), .cls_sampling_freq_rdy(samp_rdy), .cls_sampling_freq_msg(samp_msg),
    .cls_send_val(cls_send_val), .cls_send_rdy(cls_send_rdy), .cls_send_msg(cls_send_msg),
    .owner(owner), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // responses are popped from the scoreboard whenever a result handshake happens
  always @(negedge clk) begin
    #2;
    if (reset && (resp_val & resp_rdy) != 4'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_val %b with nothing outstanding", resp_val);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_val", 64'(resp_val), 64'(1) << e.ch);
        chk("resp_msg", 64'(resp_msg[e.ch]), 64'(e.res));
      end
    end
  end

  task automatic run_frame(input int ch, input bit res, input logic [3:0] drop, input int hold);
    #1;
    chk("grant", 64'(req_rdy), 64'(1) << ch);
    chk("grant_cfg_rdy", 64'(cfg_rdy), 64'(0));
    @(negedge clk);
    req_val = req_val & ~drop;
    #1;
    chk("owner", 64'(owner), 64'(ch));
    chk("recv_val", 64'(cls_recv_val), 64'(1));
    for (int s = 0; s < 8; s++) chk("frame", 64'(cls_recv_msg[s]), 64'(frames[ch][s]));
    cls_recv_rdy = 1'b1;
    @(negedge clk);
    cls_recv_rdy = 1'b0;
    #1;
    chk("send_rdy", 64'(cls_send_rdy), 64'(1));
    chk("wait_resp_val", 64'(resp_val), 64'(0));
    chk("wait_cfg_rdy", 64'(cfg_rdy), 64'(0));
    cls_send_val = 1'b1;
    cls_send_msg = res;
    sb.push_back('{ch, res});
    @(negedge clk);
    cls_send_val = 1'b0;
    if (hold > 0) resp_rdy[ch] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("hold_val", 64'(resp_val), 64'(1) << ch);
      chk("hold_msg", 64'(resp_msg[ch]), 64'(res));
      chk("hold_nogrant", 64'(req_rdy), 64'(0));
      @(negedge clk);
    end
    resp_rdy[ch] = 1'b1;
    #1;
    chk("resp_busy", 64'(busy), 64'(1));
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [1:0] a, input logic [31:0] d);
    logic [2:0] exp_v;
    exp_v = (a == 2'd3) ? 3'b000 : 3'b100 >> a;
    err_exp = err_exp | (a == 2'd3);
    cfg_val = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    #1;
    chk("cfg_rdy", 64'(cfg_rdy), 64'(1));
    @(negedge clk);
    cfg_val = 1'b0;
    #1;
    chk("cfg_port_val", 64'({freq_val, mag_val, samp_val}), 64'(exp_v));
    if (a != 2'd3) chk("cfg_port_msg", 64'(a == 2'd0 ? freq_msg : a == 2'd1 ? mag_msg : samp_msg), 64'(d));
    @(negedge clk);
    chk("cfg_err", 64'(cfg_err), 64'(err_exp));
    chk("cfg_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    fvec_t fv [5];
    cvec_t cv [3];
    fv[0] = '{0, 1'b0, 4'h0};
    fv[1] = '{1, 1'b1, 4'h0};
    fv[2] = '{2, 1'b0, 4'h0};
    fv[3] = '{3, 1'b1, 4'h0};
    fv[4] = '{0, 1'b0, 4'hF};
    cv[0] = '{2'd0, 32'hDEAD_BEEF};
    cv[1] = '{2'd3, 32'h0000_0077};
    cv[2] = '{2'd1, 32'h0000_0005};
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 8; s++)
        frames[c][s] = (c == 2) ? 32'(s + 1) : 32'hA000_0000 + 32'(c << 8) + 32'(s);
    // reset state, with requests pending that must not see a rdy
    req_val = 4'hF;
    cfg_val = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_vals", 64'({resp_val, cls_recv_val, cls_send_rdy, freq_val, mag_val, samp_val}), 64'(0));
    req_val = '0;
    cfg_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // single frame on ch2, then pointer sits at 3
    req_val = 4'b0100;
    run_frame(2, 1'b1, 4'b0100, 0);
    req_val = 4'b1010;
    run_frame(3, 1'b0, 4'b1000, 0);
    run_frame(1, 1'b1, 4'b0010, 0);
    // all channels continuously requesting
    do_reset();
    req_val = 4'hF;
    for (int i = 0; i < 5; i++) run_frame(fv[i].ch, fv[i].res, fv[i].drop, 0);
    // cfg and req together: cfg first, then frame 0, then the next cfg
    cfg_val = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = 32'h0003_0000;
    req_val = 4'b0001;
    #1;
    chk("tie_cfg_rdy", 64'(cfg_rdy), 64'(1));
    chk("tie_req_rdy", 64'(req_rdy), 64'(0));
    @(negedge clk);
    cfg_addr = 2'd2;
    cfg_data = 32'h0000_1234;
    #1;
    chk("tie_port_val", 64'({freq_val, mag_val, samp_val}), 64'(3'b010));
    chk("tie_port_msg", 64'(mag_msg), 64'(32'h0003_0000));
    @(negedge clk);
    run_frame(0, 1'b1, 4'b0001, 0);
    do_cfg(2'd2, 32'h0000_1234);
    for (int i = 0; i < 3; i++) do_cfg(cv[i].a, cv[i].d);
    // stalled response on ch1 while ch2 waits
    req_val = 4'b0110;
    run_frame(1, 1'b0, 4'b0010, 5);
    run_frame(2, 1'b0, 4'b0100, 0);
    // reset during WAIT aborts the frame
    req_val = 4'b1000;
    #1;
    chk("abort_grant", 64'(req_rdy), 64'(4'b1000));
    @(negedge clk);
    req_val = '0;
    cls_recv_rdy = 1'b1;
    @(negedge clk);
    cls_recv_rdy = 1'b0;
    #1;
    chk("abort_wait", 64'(cls_send_rdy), 64'(1));
    reset = 1'b0;
    #1;
    chk("abort_vals", 64'({resp_val, req_rdy, cfg_rdy, cls_recv_val, cls_send_rdy, freq_val, mag_val, samp_val}), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_err", 64'(cfg_err), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
    chk("post_owner", 64'(owner), 64'(0));
    req_val = 4'hF;
    run_frame(0, 1'b1, 4'hF, 0);
    repeat (4) @(negedge clk);
    chk("post_idle_resp", 64'(resp_val), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
